// File: rtl/uart_tx_fifo_if.sv
// CPU request/response and UART request signals of the TX FIFO, bundled for port hookup.
// slave is the FIFO's view; master is the CPU/UART side that surrounds it.
interface uart_tx_fifo_if;
   logic        cpu_req_valid;
   logic        cpu_req_ready;
   logic [7:0]  cpu_req_addr;
   logic        cpu_req_write;
   logic [31:0] cpu_req_data;
   logic [31:0] cpu_resp_data;
   logic        cpu_resp_valid;
   logic        cpu_resp_ready;
   logic        uart_req_valid;
   logic        uart_req_ready;
   logic [7:0]  uart_req_addr;
   logic        uart_req_write;
   logic [31:0] uart_req_data;

   modport slave (
      input  cpu_req_valid, cpu_req_addr, cpu_req_write, cpu_req_data, cpu_resp_ready,
      input  uart_req_ready,
      output cpu_req_ready, cpu_resp_data, cpu_resp_valid,
      output uart_req_valid, uart_req_addr, uart_req_write, uart_req_data
   );

   modport master (
      output cpu_req_valid, cpu_req_addr, cpu_req_write, cpu_req_data, cpu_resp_ready,
      output uart_req_ready,
      input  cpu_req_ready, cpu_resp_data, cpu_resp_valid,
      input  uart_req_valid, uart_req_addr, uart_req_write, uart_req_data
   );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO between the CPU bus and the UART TX register, with a drain FSM and a STATUS register.
//   state   | meaning
//   S_IDLE  | no offer outstanding; leave when the FIFO holds a byte
//   S_ISSUE | head byte offered to the UART, held until accepted
//   S_GAP   | one dead cycle after acceptance so the UART's ready can fall
module uart_tx_fifo #(
   parameter int DEPTH = 16,
   parameter int PTR_W = 4
) (
   input logic           clk,
   input logic           reset,
   uart_tx_fifo_if.slave bus
);
   localparam logic [PTR_W:0] FULL_CNT  = (PTR_W + 1)'(DEPTH);
   localparam logic [31:0]    IDLE_RESP = 32'hdeadbeef;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   state_t           state;
   logic [7:0]       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic             overflow;
   logic             uart_valid_q;
   logic [7:0]       uart_byte_q;
   logic             resp_valid_q;
   logic [31:0]      resp_data_q;

   logic        empty, full;
   logic        push, push_ok, pop, flush, status_rd;
   logic [31:0] status;

   assign empty     = (count == '0);
   assign full      = (count == FULL_CNT);
   assign push      = bus.cpu_req_valid & bus.cpu_req_write & (bus.cpu_req_addr == 8'h00);
   assign pop       = uart_valid_q & bus.uart_req_ready;
   // A pop in the same cycle frees the slot, so a push at full still lands.
   assign push_ok   = push & (~full | pop);
   assign flush     = bus.cpu_req_valid & bus.cpu_req_write & (bus.cpu_req_addr == 8'h0c)
                      & bus.cpu_req_data[0];
   assign status_rd = bus.cpu_req_valid & ~bus.cpu_req_write & bus.cpu_resp_ready
                      & (bus.cpu_req_addr == 8'h08);
   assign status    = (32'(count) << 8) | {29'd0, overflow, full, empty};

   assign bus.cpu_req_ready  = ~full;
   assign bus.cpu_resp_valid = resp_valid_q;
   assign bus.cpu_resp_data  = resp_data_q;
   assign bus.uart_req_valid = uart_valid_q;
   assign bus.uart_req_addr  = 8'h00;
   assign bus.uart_req_write = 1'b1;
   assign bus.uart_req_data  = {24'd0, uart_byte_q};

   always_ff @(posedge clk) begin
      if (!reset && !flush && push_ok) begin
         mem[wr_ptr] <= bus.cpu_req_data[7:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         overflow     <= 1'b0;
         state        <= S_IDLE;
         uart_valid_q <= 1'b0;
         uart_byte_q  <= '0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= IDLE_RESP;
      end else begin
         resp_valid_q <= status_rd;
         resp_data_q  <= status_rd ? status : IDLE_RESP;
         if (flush) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow     <= 1'b0;
            state        <= S_IDLE;
            uart_valid_q <= 1'b0;
         end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (push && !push_ok) overflow <= 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop) count <= count + 1'b1;
            else if (pop && !push_ok) count <= count - 1'b1;

            unique case (state)
               S_IDLE: begin
                  if (!empty) begin
                     state        <= S_ISSUE;
                     uart_valid_q <= 1'b1;
                     uart_byte_q  <= mem[rd_ptr];
                  end
               end
               S_ISSUE: begin
                  if (bus.uart_req_ready) begin
                     state        <= S_GAP;
                     uart_valid_q <= 1'b0;
                  end
               end
               S_GAP: begin
                  state <= S_IDLE;
               end
               default: begin
                  state        <= S_IDLE;
                  uart_valid_q <= 1'b0;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: status reads, drain ordering, full/overflow, flush and reset.
module tb_uart_tx_fifo;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;

   uart_tx_fifo_if bus ();

   uart_tx_fifo #(.DEPTH(16), .PTR_W(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_write(input logic [7:0] a, input logic [31:0] d);
      bus.cpu_req_valid = 1'b1;
      bus.cpu_req_write = 1'b1;
      bus.cpu_req_addr  = a;
      bus.cpu_req_data  = d;
      tick();
      bus.cpu_req_valid = 1'b0;
      bus.cpu_req_write = 1'b0;
   endtask

   task automatic cpu_read(input logic [7:0] a, output logic v, output logic [31:0] d);
      bus.cpu_req_valid  = 1'b1;
      bus.cpu_req_write  = 1'b0;
      bus.cpu_req_addr   = a;
      bus.cpu_resp_ready = 1'b1;
      tick();
      bus.cpu_req_valid = 1'b0;
      v = bus.cpu_resp_valid;
      d = bus.cpu_resp_data;
   endtask

   task automatic wait_valid(input int limit, output logic seen);
      seen = 1'b0;
      for (int i = 0; i < limit; i++) begin
         if (bus.uart_req_valid) begin
            seen = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic check_status(input string name, input logic [31:0] exp);
      logic        v;
      logic [31:0] d;
      cpu_read(8'h08, v, d);
      vectors++;
      if (v !== 1'b1 || d !== exp) begin
         miscompares++;
         $display("FAIL %s: resp_valid=%0b data=%08h, required valid=1 data=%08h", name, v, d, exp);
      end
   endtask

   task automatic test_reset();
      logic        v;
      logic [31:0] d;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      vectors++;
      if (bus.uart_req_valid !== 1'b0 || bus.cpu_resp_valid !== 1'b0 ||
          bus.cpu_resp_data !== 32'hdeadbeef || bus.cpu_req_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_outputs: uvalid=%0b rvalid=%0b rdata=%08h rdy=%0b, required 0 0 deadbeef 1",
                  bus.uart_req_valid, bus.cpu_resp_valid, bus.cpu_resp_data, bus.cpu_req_ready);
      end
      vectors++;
      if (bus.uart_req_addr !== 8'h00 || bus.uart_req_write !== 1'b1) begin
         miscompares++;
         $display("FAIL uart_consts: addr=%02h write=%0b, required 00 1", bus.uart_req_addr, bus.uart_req_write);
      end
      check_status("status_after_reset", 32'h0000_0001);
      tick();
      vectors++;
      if (bus.cpu_resp_valid !== 1'b0 || bus.cpu_resp_data !== 32'hdeadbeef) begin
         miscompares++;
         $display("FAIL resp_one_cycle: valid=%0b data=%08h, required 0 deadbeef", bus.cpu_resp_valid, bus.cpu_resp_data);
      end
      cpu_read(8'h04, v, d);
      vectors++;
      if (v !== 1'b0 || d !== 32'hdeadbeef) begin
         miscompares++;
         $display("FAIL read_other_addr: valid=%0b data=%08h, required 0 deadbeef", v, d);
      end
   endtask

   task automatic test_drain_order();
      logic [7:0] exp_b [3];
      logic       seen;
      logic       stable;
      exp_b = '{8'h41, 8'h42, 8'h43};
      bus.uart_req_ready = 1'b0;
      for (int i = 0; i < 3; i++) cpu_write(8'h00, {24'd0, exp_b[i]});
      for (int i = 0; i < 3; i++) begin
         wait_valid(20, seen);
         vectors++;
         if (seen !== 1'b1) begin
            miscompares++;
            $display("FAIL drain_offer_%0d: valid=0 after 20 cycles, required 1", i);
         end
         stable = 1'b1;
         for (int c = 0; c < 500; c++) begin
            if (bus.uart_req_valid !== 1'b1 || bus.uart_req_data !== {24'd0, exp_b[i]}) stable = 1'b0;
            tick();
         end
         vectors++;
         if (stable !== 1'b1 || bus.uart_req_data !== {24'd0, exp_b[i]}) begin
            miscompares++;
            $display("FAIL drain_byte_%0d: data=%08h stable=%0b, required %08h held", i,
                     bus.uart_req_data, stable, {24'd0, exp_b[i]});
         end
         bus.uart_req_ready = 1'b1;
         tick();
         bus.uart_req_ready = 1'b0;
         vectors++;
         if (bus.uart_req_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL gap_after_accept_%0d: valid=%0b, required 0", i, bus.uart_req_valid);
         end
      end
      tick();
      tick();
      check_status("status_drained", 32'h0000_0001);
   endtask

   task automatic test_back_to_back();
      int gap;
      bus.uart_req_ready = 1'b0;
      cpu_write(8'h00, 32'h0000_0061);
      cpu_write(8'h00, 32'h0000_0062);
      tick();
      bus.uart_req_ready = 1'b1;
      tick();
      gap = 1;
      while (bus.uart_req_valid !== 1'b1 && gap < 10) begin
         tick();
         gap++;
      end
      vectors++;
      if (gap != 3 || bus.uart_req_data !== 32'h0000_0062) begin
         miscompares++;
         $display("FAIL offer_spacing: gap=%0d data=%08h, required 3 00000062", gap, bus.uart_req_data);
      end
      tick();
      bus.uart_req_ready = 1'b0;
      tick();
      tick();
      check_status("status_b2b_empty", 32'h0000_0001);
   endtask

   task automatic test_full_overflow();
      logic [7:0] got [$];
      logic [7:0] exp_q [$];
      bus.uart_req_ready = 1'b0;
      for (int i = 0; i < 17; i++) begin
         cpu_write(8'h00, 32'(8'h10 + i));
         if (i == 14) begin
            vectors++;
            if (bus.cpu_req_ready !== 1'b1) begin
               miscompares++;
               $display("FAIL ready_at_15: ready=%0b, required 1", bus.cpu_req_ready);
            end
         end
         if (i == 15) begin
            vectors++;
            if (bus.cpu_req_ready !== 1'b0) begin
               miscompares++;
               $display("FAIL ready_at_16: ready=%0b, required 0", bus.cpu_req_ready);
            end
         end
      end
      check_status("status_full_overflow", 32'h0000_1006);
      vectors++;
      if (bus.uart_req_valid !== 1'b1 || bus.uart_req_data !== 32'h0000_0010) begin
         miscompares++;
         $display("FAIL head_at_full: valid=%0b data=%08h, required 1 00000010", bus.uart_req_valid, bus.uart_req_data);
      end
      // push and pop together while full
      bus.uart_req_ready = 1'b1;
      cpu_write(8'h00, 32'h0000_0055);
      bus.uart_req_ready = 1'b0;
      check_status("status_push_pop_full", 32'h0000_1006);
      for (int i = 1; i < 16; i++) exp_q.push_back(8'(8'h10 + i));
      exp_q.push_back(8'h55);
      bus.uart_req_ready = 1'b1;
      for (int c = 0; c < 200 && got.size() < 16; c++) begin
         if (bus.uart_req_valid === 1'b1) got.push_back(bus.uart_req_data[7:0]);
         tick();
      end
      bus.uart_req_ready = 1'b0;
      vectors++;
      if (got.size() != 16) begin
         miscompares++;
         $display("FAIL drain_count_full: got %0d bytes, required 16", got.size());
      end
      for (int i = 0; i < 16 && i < got.size(); i++) begin
         vectors++;
         if (got[i] !== exp_q[i]) begin
            miscompares++;
            $display("FAIL full_drain_byte_%0d: data=%02h, required %02h", i, got[i], exp_q[i]);
         end
      end
      tick();
      tick();
      check_status("status_sticky_overflow", 32'h0000_0005);
      cpu_write(8'h0c, 32'h0000_0001);
      check_status("status_flush_clears_ovf", 32'h0000_0001);
   endtask

   task automatic test_flush();
      logic seen;
      bus.uart_req_ready = 1'b0;
      for (int i = 0; i < 4; i++) cpu_write(8'h00, 32'(8'hA1 + i));
      tick();
      vectors++;
      if (bus.uart_req_valid !== 1'b1 || bus.uart_req_data !== 32'h0000_00A1) begin
         miscompares++;
         $display("FAIL issue_before_flush: valid=%0b data=%08h, required 1 000000a1", bus.uart_req_valid, bus.uart_req_data);
      end
      cpu_write(8'h0c, 32'h0000_0001);
      vectors++;
      if (bus.uart_req_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL valid_after_flush: valid=%0b, required 0", bus.uart_req_valid);
      end
      check_status("status_after_flush", 32'h0000_0001);
      cpu_write(8'h00, 32'h0000_007E);
      wait_valid(10, seen);
      vectors++;
      if (seen !== 1'b1 || bus.uart_req_data !== 32'h0000_007E) begin
         miscompares++;
         $display("FAIL drain_after_flush: valid=%0b data=%08h, required 1 0000007e", seen, bus.uart_req_data);
      end
      bus.uart_req_ready = 1'b1;
      tick();
      bus.uart_req_ready = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_reset_mid_drain();
      logic seen;
      logic rose;
      bus.uart_req_ready = 1'b0;
      cpu_write(8'h00, 32'h0000_00C1);
      cpu_write(8'h00, 32'h0000_00C2);
      wait_valid(10, seen);
      vectors++;
      if (seen !== 1'b1) begin
         miscompares++;
         $display("FAIL offer_before_reset: valid=0, required 1");
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      vectors++;
      if (bus.uart_req_valid !== 1'b0 || bus.cpu_resp_valid !== 1'b0 ||
          bus.cpu_resp_data !== 32'hdeadbeef || bus.cpu_req_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_mid_drain: uvalid=%0b rvalid=%0b rdata=%08h rdy=%0b, required 0 0 deadbeef 1",
                  bus.uart_req_valid, bus.cpu_resp_valid, bus.cpu_resp_data, bus.cpu_req_ready);
      end
      bus.uart_req_ready = 1'b1;
      rose = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (bus.uart_req_valid !== 1'b0) rose = 1'b1;
         tick();
      end
      bus.uart_req_ready = 1'b0;
      vectors++;
      if (rose !== 1'b0) begin
         miscompares++;
         $display("FAIL offer_after_reset: valid rose with no push, required none");
      end
      check_status("status_after_mid_reset", 32'h0000_0001);
   endtask

   initial begin
      bus.cpu_req_valid  = 1'b0;
      bus.cpu_req_write  = 1'b0;
      bus.cpu_req_addr   = 8'h00;
      bus.cpu_req_data   = 32'd0;
      bus.cpu_resp_ready = 1'b1;
      bus.uart_req_ready = 1'b0;
      test_reset();
      test_drain_order();
      test_back_to_back();
      test_full_overflow();
      test_flush();
      test_reset_mid_drain();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
